// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per stage, carry registered between
// stages, upper operand bits skewed forward and finished sum bits accumulated to the output.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic advance;

  // The whole pipeline moves together; a full pipeline stalls only on a held result.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int IW = WIDTH - g * CHUNK;

      logic [IW-1:0]          xin;
      logic [IW-1:0]          yin;
      logic                   c_prev;
      logic                   v_prev;
      logic [CHUNK:0]         sum;
      logic [(g+1)*CHUNK-1:0] s_d;
      logic [(g+1)*CHUNK-1:0] s_q;
      logic                   c_q;
      logic                   v_q;

      if (g == 0) begin : g_head
        assign xin    = x;
        assign yin    = y;
        assign c_prev = c_in;
        assign v_prev = in_valid;
        assign s_d    = sum[CHUNK-1:0];
      end else begin : g_tail
        // Operands arrive already shifted so that the current slice sits at bit 0.
        assign xin    = g_stage[g-1].g_skew.xu_q;
        assign yin    = g_stage[g-1].g_skew.yu_q;
        assign c_prev = g_stage[g-1].c_q;
        assign v_prev = g_stage[g-1].v_q;
        assign s_d    = {sum[CHUNK-1:0], g_stage[g-1].s_q};
      end

      assign sum = {1'b0, xin[CHUNK-1:0]} + {1'b0, yin[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_prev};

      // Stage slice sum, carry and valid register.
      always_ff @(posedge clock) begin
        if (reset) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
        end else if (advance) begin
          v_q <= v_prev;
          c_q <= sum[CHUNK];
          s_q <= s_d;
        end else begin
          v_q <= v_q;
          c_q <= c_q;
          s_q <= s_q;
        end
      end

      if (g < STAGES - 1) begin : g_skew
        logic [IW-CHUNK-1:0] xu_q;
        logic [IW-CHUNK-1:0] yu_q;

        // Delay the not-yet-added operand slices to meet their carry.
        always_ff @(posedge clock) begin
          if (reset) begin
            xu_q <= '0;
            yu_q <= '0;
          end else if (advance) begin
            xu_q <= xin[IW-1:CHUNK];
            yu_q <= yin[IW-1:CHUNK];
          end else begin
            xu_q <= xu_q;
            yu_q <= yu_q;
          end
        end
      end else begin : g_last
        logic ovf_q;

        // Signed overflow from the top slice MSBs of x, y and the final sum.
        always_ff @(posedge clock) begin
          if (reset) begin
            ovf_q <= 1'b0;
          end else if (advance) begin
            ovf_q <= (xin[CHUNK-1] == yin[CHUNK-1]) && (sum[CHUNK-1] != xin[CHUNK-1]);
          end else begin
            ovf_q <= ovf_q;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
